// File: rtl/tt_dpll_pkg.sv
// Shared DPLL types and default lock-monitor constants.
package tt_dpll_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    SLIPPING  = 2'd3
  } lock_state_e;

  localparam int LOCK_CYCLES_DEF = 64;
  localparam int UNLOCK_ERRS_DEF = 4;
  localparam int WINDOW_DEF      = 32;
  localparam int SLIP_W_DEF      = 8;

endpackage

// File: rtl/tt_sat_counter.sv
// Saturating up-counter with clear and parallel load (load used for scan shifting).
module tt_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_lock_monitor.sv
// DPLL lock detector with quiet-run acquisition, slip-window hysteresis and scan chain.
// Optional sticky loss-of-lock flag enabled by TT_LOCK_MON_STICKY_EN.
module tt_lock_monitor
  import tt_dpll_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int UNLOCK_ERRS = UNLOCK_ERRS_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int SLIP_W      = SLIP_W_DEF
) (
  input  logic              i_clk_gen,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_clear_lost,
  output logic              o_locked,
  output logic [1:0]        o_state,
  output logic [SLIP_W-1:0] o_slip_cnt,
  output logic              o_lock_lost,
  input  logic              i_scan_en,
  input  logic              i_scan_in,
  output logic              o_scan_out
);

  localparam int QW = $clog2(LOCK_CYCLES + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam int WW = $clog2(WINDOW + 1);
`ifdef TT_LOCK_MON_STICKY_EN
  localparam int LW = 1;
`else
  localparam int LW = 0;
`endif
  localparam int CHAIN_W = 2 + QW + EW + WW + SLIP_W + LW + 1;
  localparam int Q_OFF   = 2;
  localparam int E_OFF   = Q_OFF + QW;
  localparam int W_OFF   = E_OFF + EW;
  localparam int S_OFF   = W_OFF + WW;
  localparam int L_OFF   = S_OFF + SLIP_W;

  localparam logic [QW-1:0] LOCK_LIM = QW'(LOCK_CYCLES);
  localparam logic [EW-1:0] ERR_LIM  = EW'(UNLOCK_ERRS);
  localparam logic [WW-1:0] WIN_LIM  = WW'(WINDOW);

  lock_state_e       state_q, state_d;
  logic [QW-1:0]     q_cnt_q, q_cnt_d, q_inc;
  logic [EW-1:0]     err_cnt_q, err_cnt_d, err_inc;
  logic [WW-1:0]     win_cnt_q, win_cnt_d, win_inc;
  logic              locked_q, locked_d;
  logic              err, unlock_evt;
  logic [SLIP_W-1:0] slip_cnt;
  logic [CHAIN_W-2:0] chain_lo;
  logic [CHAIN_W-1:0] chain_sh;

  assign err     = i_up | i_down;
  assign q_inc   = q_cnt_q + 1'b1;
  assign err_inc = err_cnt_q + EW'(err);
  assign win_inc = win_cnt_q + 1'b1;
  // Every register moves one place toward o_scan_out; i_scan_in enters at state[0].
  assign chain_sh = {chain_lo, i_scan_in};

  always_comb begin
    state_d    = state_q;
    q_cnt_d    = q_cnt_q;
    err_cnt_d  = err_cnt_q;
    win_cnt_d  = win_cnt_q;
    unlock_evt = 1'b0;
    locked_d   = 1'b0;
    if (i_scan_en) begin
      state_d   = lock_state_e'(chain_sh[1:0]);
      q_cnt_d   = chain_sh[Q_OFF +: QW];
      err_cnt_d = chain_sh[E_OFF +: EW];
      win_cnt_d = chain_sh[W_OFF +: WW];
      locked_d  = chain_sh[CHAIN_W-1];
    end else if (!i_enable) begin
      state_d   = UNLOCKED;
      q_cnt_d   = '0;
      err_cnt_d = '0;
      win_cnt_d = '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (err) begin
            q_cnt_d = '0;
          end else begin
            state_d = ACQUIRING;
            q_cnt_d = QW'(1);
          end
        end
        ACQUIRING: begin
          if (err) begin
            state_d = UNLOCKED;
            q_cnt_d = '0;
          end else if (q_inc == LOCK_LIM) begin
            state_d = LOCKED;
            q_cnt_d = '0;
          end else begin
            q_cnt_d = q_inc;
          end
        end
        LOCKED: begin
          if (err) begin
            if (ERR_LIM == EW'(1)) begin
              unlock_evt = 1'b1;
            end else begin
              state_d   = SLIPPING;
              err_cnt_d = EW'(1);
              win_cnt_d = WW'(1);
            end
          end
        end
        SLIPPING: begin
          // Error threshold outranks window expiry on the same edge.
          if (err_inc == ERR_LIM) begin
            unlock_evt = 1'b1;
          end else if (win_inc == WIN_LIM) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
            win_cnt_d = '0;
          end else begin
            err_cnt_d = err_inc;
            win_cnt_d = win_inc;
          end
        end
        default: state_d = UNLOCKED;
      endcase
      if (unlock_evt) begin
        state_d   = UNLOCKED;
        q_cnt_d   = '0;
        err_cnt_d = '0;
        win_cnt_d = '0;
      end
      locked_d = (state_d == LOCKED) || (state_d == SLIPPING);
    end
  end

  always_ff @(posedge i_clk_gen) begin
    if (!i_rst_n) begin
      state_q   <= UNLOCKED;
      q_cnt_q   <= '0;
      err_cnt_q <= '0;
      win_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_cnt_q   <= q_cnt_d;
      err_cnt_q <= err_cnt_d;
      win_cnt_q <= win_cnt_d;
      locked_q  <= locked_d;
    end
  end

  tt_sat_counter #(
    .W (SLIP_W)
  ) u_slip_cnt (
    .clk_i      (i_clk_gen),
    .rst_ni     (i_rst_n),
    .inc_i      (unlock_evt),
    .clr_i      (1'b0),
    .load_i     (i_scan_en),
    .load_val_i (chain_sh[S_OFF +: SLIP_W]),
    .cnt_o      (slip_cnt)
  );

`ifdef TT_LOCK_MON_STICKY_EN
  logic lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if (i_scan_en) begin
      lost_d = chain_sh[L_OFF];
    end else if (unlock_evt) begin
      lost_d = 1'b1;
    end else if (i_clear_lost) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk_gen) begin
    if (!i_rst_n) begin
      lost_q <= 1'b0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign o_lock_lost = lost_q;
  assign chain_lo    = {lost_q, slip_cnt, win_cnt_q, err_cnt_q, q_cnt_q, state_q};
`else
  logic unused_clear_lost;
  assign unused_clear_lost = i_clear_lost;
  assign o_lock_lost       = 1'b0;
  assign chain_lo          = {slip_cnt, win_cnt_q, err_cnt_q, q_cnt_q, state_q};
`endif

  assign o_locked   = locked_q;
  assign o_state    = state_q;
  assign o_slip_cnt = slip_cnt;
  assign o_scan_out = locked_q;

endmodule

// File: tb/tb_tt_lock_monitor.sv
// Directed bench for tt_lock_monitor: default build plus a SLIP_W=2 instance for saturation.
`timescale 1ns/1ps
module tb_tt_lock_monitor;

  localparam int LC  = 64;
  localparam int UE  = 4;
  localparam int WIN = 32;
  localparam int SW  = 8;
  localparam int SW2 = 2;
  localparam int QW  = $clog2(LC + 1);
  localparam int EW  = $clog2(UE + 1);
  localparam int WW  = $clog2(WIN + 1);
`ifdef TT_LOCK_MON_STICKY_EN
  localparam int LB     = 1;
  localparam bit STICKY = 1'b1;
`else
  localparam int LB     = 0;
  localparam bit STICKY = 1'b0;
`endif
  localparam int N1 = 2 + QW + EW + WW + SW + LB + 1;
  localparam int N2 = 2 + QW + EW + WW + SW2 + LB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, up, dn, clr;
  logic scan_en, scan_in, scan_en2, scan_in2;
  logic locked1, lost1, so1, locked2, lost2, so2;
  logic [1:0] state1, state2;
  logic [SW-1:0]  slip1;
  logic [SW2-1:0] slip2;

  tt_lock_monitor #(.LOCK_CYCLES(LC), .UNLOCK_ERRS(UE), .WINDOW(WIN), .SLIP_W(SW)) dut (
    .i_clk_gen(clk), .i_rst_n(rst_n), .i_enable(en), .i_up(up), .i_down(dn),
    .i_clear_lost(clr), .o_locked(locked1), .o_state(state1), .o_slip_cnt(slip1),
    .o_lock_lost(lost1), .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(so1)
  );

  tt_lock_monitor #(.LOCK_CYCLES(LC), .UNLOCK_ERRS(UE), .WINDOW(WIN), .SLIP_W(SW2)) dut2 (
    .i_clk_gen(clk), .i_rst_n(rst_n), .i_enable(en), .i_up(up), .i_down(dn),
    .i_clear_lost(clr), .o_locked(locked2), .o_state(state2), .o_slip_cnt(slip2),
    .o_lock_lost(lost2), .i_scan_en(scan_en2), .i_scan_in(scan_in2), .o_scan_out(so2)
  );

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;
  bit scanning = 1'b0;

  // Behavioural model: quiet-run length, slip-window age/errors, total loss-of-lock events.
  int m_state = 0, m_quiet = 0, m_errs = 0, m_age = 0, m_slips = 0;
  bit m_lost = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit r_n, input bit e, input bit er, input bit cl);
    bit unlock = 1'b0;
    if (!r_n) begin
      m_state = 0; m_quiet = 0; m_errs = 0; m_age = 0; m_slips = 0; m_lost = 1'b0;
      return;
    end
    if (!e) begin
      m_state = 0; m_quiet = 0; m_errs = 0; m_age = 0;
      if (cl) m_lost = 1'b0;
      return;
    end
    case (m_state)
      0: if (er) m_quiet = 0; else begin m_quiet = 1; m_state = 1; end
      1: if (er) begin m_state = 0; m_quiet = 0; end
         else begin
           m_quiet++;
           if (m_quiet == LC) begin m_state = 2; m_quiet = 0; end
         end
      2: if (er) begin
           m_errs = 1; m_age = 1;
           if (m_errs >= UE) unlock = 1'b1; else m_state = 3;
         end
      default: begin
        m_age++;
        m_errs += int'(er);
        if (m_errs == UE) unlock = 1'b1;
        else if (m_age == WIN) begin m_state = 2; m_errs = 0; m_age = 0; end
      end
    endcase
    if (unlock) begin
      m_state = 0; m_quiet = 0; m_errs = 0; m_age = 0; m_slips++; m_lost = 1'b1;
    end else if (cl) begin
      m_lost = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!scanning) model_step(rst_n, en, up | dn, clr);
  end

  always @(negedge clk) begin
    if (check_on && !scanning) begin
      check("locked",   locked1, int'(m_state >= 2));
      check("state",    state1,  m_state);
      check("slip",     slip1,   sat(m_slips, SW));
      check("lost",     lost1,   STICKY ? int'(m_lost) : 0);
      check("scan_out", so1,     int'(m_state >= 2));
      check("locked2",  locked2, int'(m_state >= 2));
      check("state2",   state2,  m_state);
      check("slip2",    slip2,   sat(m_slips, SW2));
      check("lost2",    lost2,   STICKY ? int'(m_lost) : 0);
      check("scan_out2", so2,    int'(m_state >= 2));
    end
  end

  task automatic run(input int n, input bit u, input bit d);
    up = u;
    dn = d;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    up = 1'b0;
    dn = 1'b0;
  endtask

  // Shift a pattern through, then shift the captured original contents back in.
  task automatic scan_chain(input bit sel);
    int n;
    bit pat[$];
    bit cap[$];
    n = sel ? N2 : N1;
    scanning = 1'b1;
    if (sel) scan_en2 = 1'b1; else scan_en = 1'b1;
    for (int i = 0; i < 2 * n; i++) begin
      bit b;
      bit o;
      if (i < n) begin
        b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        pat.push_back(b);
      end else begin
        b = cap[i-n];
      end
      if (sel) scan_in2 = b; else scan_in = b;
      o = sel ? so2 : so1;
      if (i < n) cap.push_back(o);
      else check(sel ? "scan2_pattern" : "scan1_pattern", int'(o), int'(pat[i-n]));
      @(posedge clk);
      #1;
    end
    scan_en = 1'b0; scan_en2 = 1'b0; scan_in = 1'b0; scan_in2 = 1'b0;
    scanning = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b0; dn = 1'b0; clr = 1'b0;
    scan_en = 1'b0; scan_in = 1'b0; scan_en2 = 1'b0; scan_in2 = 1'b0;
    repeat (2) begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    up = 1'b0; dn = 1'b0;
    check_on = 1'b1;
    check("rst_state", state1, 0);
    check("rst_locked", locked1, 0);
    check("rst_slip", slip1, 0);
    check("rst_lost", lost1, 0);

    rst_n = 1'b1;
    run(63, 0, 0);
    check("acq_63_locked", locked1, 0);
    check("acq_63_state", state1, 1);
    run(1, 0, 0);
    check("acq_64_locked", locked1, 1);
    check("acq_64_state", state1, 2);

    rst_n = 1'b0;
    run(1, 0, 0);
    rst_n = 1'b1;
    run(40, 0, 0);
    run(1, 1, 0);
    check("err40_state", state1, 0);
    run(63, 0, 0);
    check("err40_63_locked", locked1, 0);
    run(1, 0, 0);
    check("err40_64_locked", locked1, 1);

    run(1, 1, 0);
    run(5, 0, 0);
    run(1, 0, 1);
    run(5, 0, 0);
    run(1, 1, 1);
    check("hyst3_locked", locked1, 1);
    check("hyst3_state", state1, 3);
    run(18, 0, 0);
    check("hyst_win31_state", state1, 3);
    run(1, 0, 0);
    check("hyst_win32_state", state1, 2);
    check("hyst_win32_slip", slip1, 0);

    run(1, 1, 0);
    run(2, 0, 0);
    run(1, 1, 0);
    run(2, 0, 0);
    run(1, 0, 1);
    run(2, 0, 0);
    run(1, 1, 0);
    check("hyst4_locked", locked1, 0);
    check("hyst4_state", state1, 0);
    check("hyst4_slip", slip1, 1);
    check("hyst4_lost", lost1, int'(STICKY));

    repeat (5) begin
      run(64, 0, 0);
      run(4, 1, 0);
    end
    check("sat_slip8", slip1, 6);
    check("sat_slip2", slip2, 3);

    run(64, 0, 0);
    check("en_pre_locked", locked1, 1);
    en = 1'b0;
    run(1, 0, 0);
    check("en_off_state", state1, 0);
    check("en_off_locked", locked1, 0);
    check("en_off_slip", slip1, 6);
    check("en_off_lost", lost1, int'(STICKY));
    en = 1'b1;
    clr = 1'b1;
    run(1, 1, 0);
    clr = 1'b0;
    check("clear_lost", lost1, 0);
    run(64, 0, 0);
    run(3, 1, 0);
    clr = 1'b1;
    run(1, 1, 0);
    clr = 1'b0;
    check("set_wins_lost", lost1, int'(STICKY));
    check("set_wins_slip", slip1, 7);
    check("set_wins_slip2", slip2, 3);

    run(64, 0, 0);
    check("scan_pre_state", state1, 2);
    scan_chain(1'b0);
    scan_chain(1'b1);
    run(2, 0, 0);
    check("scan_post_state1", state1, 2);
    check("scan_post_state2", state2, 2);
    run(4, 1, 0);
    check("scan_resume_locked", locked1, 0);
    check("scan_resume_slip", slip1, 8);
    run(2, 0, 0);

    check_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
